// File: rtl/dig_readout_pkg.sv
// Shared types and defaults for the comparator-count readout stage.
package dig_readout_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StWin,
        StCapt,
        StAcc,
        StDone
    } state_e;

    localparam int unsigned DefCw      = 8;
    localparam int unsigned DefWinCyc  = 1024;
    localparam int unsigned DefNAvg    = 4;
    localparam int unsigned DefRstCyc  = 2;
    localparam int unsigned DefMaxTry  = 4;
    localparam int unsigned SyncStages = 2;

    // Cycles from the start request to valid, assuming no capture retries.
    function automatic int unsigned expected_latency(input int unsigned n_avg,
                                                     input int unsigned rst_cyc,
                                                     input int unsigned win_cyc);
        return n_avg * (rst_cyc + win_cyc + 2) + 1;
    endfunction

endpackage

// File: rtl/dig_sync_bus.sv
// Per-bit multi-flop synchronizer for a bus from an unrelated clock domain.
module dig_sync_bus
    import dig_readout_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [SyncStages];

    // Shift the asynchronous value through the synchronizer chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SyncStages; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < SyncStages; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[SyncStages-1];

endmodule

// File: rtl/dig_readout.sv
// Windowed capture and accumulation of the comparator pulse counter.
module dig_readout
    import dig_readout_pkg::*;
#(
    parameter int unsigned CW      = DefCw,
    parameter int unsigned WIN_CYC = DefWinCyc,
    parameter int unsigned N_AVG   = DefNAvg,
    parameter int unsigned ACC_W   = CW + $clog2(N_AVG),
    parameter int unsigned RST_CYC = DefRstCyc,
    parameter int unsigned MAX_TRY = DefMaxTry
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CW-1:0]    cnt_in_i,
    output logic             cnt_rst_o,
    output logic             busy_o,
    output logic [ACC_W-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             ovf_o,
    output logic             err_o
);

    localparam int unsigned RcW = $clog2(RST_CYC + 1);
    localparam int unsigned WcW = $clog2(WIN_CYC);
    localparam int unsigned TcW = $clog2(MAX_TRY + 1);
    localparam int unsigned IxW = $clog2(N_AVG + 1);

    localparam logic [RcW-1:0] RstLast = RcW'(RST_CYC - 1);
    localparam logic [WcW-1:0] WinLast = WcW'(WIN_CYC - 1);
    localparam logic [TcW-1:0] TryLast = TcW'(MAX_TRY - 1);
    localparam logic [IxW-1:0] IdxLast = IxW'(N_AVG - 1);

    state_e           state_q, state_d;
    logic [RcW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [WcW-1:0]   win_cnt_q, win_cnt_d;
    logic [TcW-1:0]   try_q, try_d;
    logic [IxW-1:0]   idx_q, idx_d;
    logic             wrap_q, wrap_d;
    logic [CW-1:0]    sample_q, sample_d;
    logic [CW-1:0]    cs_prev_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic             cnt_rst_q, cnt_rst_d;

    logic [CW-1:0]    cs;
    logic [CW-1:0]    acc_sample;
    logic [ACC_W-1:0] acc_sum;

    dig_sync_bus #(
        .WIDTH(CW)
    ) u_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (cnt_in_i),
        .q_o  (cs)
    );

    // State and datapath registers; reset holds the external counter cleared.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            rst_cnt_q <= '0;
            win_cnt_q <= '0;
            try_q     <= '0;
            idx_q     <= '0;
            wrap_q    <= 1'b0;
            sample_q  <= '0;
            cs_prev_q <= '0;
            acc_q     <= '0;
            data_q    <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            cnt_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            win_cnt_q <= win_cnt_d;
            try_q     <= try_d;
            idx_q     <= idx_d;
            wrap_q    <= wrap_d;
            sample_q  <= sample_d;
            cs_prev_q <= cs;
            acc_q     <= acc_d;
            data_q    <= data_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            cnt_rst_q <= cnt_rst_d;
        end
    end

    // Next-state logic for the measurement sequence.
    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        win_cnt_d  = win_cnt_q;
        try_d      = try_q;
        idx_d      = idx_q;
        wrap_d     = wrap_q;
        sample_d   = sample_q;
        acc_d      = acc_q;
        data_d     = data_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        acc_sample = wrap_q ? {CW{1'b1}} : sample_q;
        acc_sum    = acc_q + ACC_W'(acc_sample);

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d   = StClr;
                    acc_d     = '0;
                    ovf_d     = 1'b0;
                    err_d     = 1'b0;
                    idx_d     = '0;
                    rst_cnt_d = '0;
                    wrap_d    = 1'b0;
                    try_d     = '0;
                end
            end
            StClr: begin
                if (rst_cnt_q == RstLast) begin
                    state_d   = StWin;
                    win_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            StWin: begin
                // The first window cycle still compares against a pre-clear value.
                if (win_cnt_q != '0 && cs_prev_q[CW-1] && !cs[CW-1]) wrap_d = 1'b1;
                if (win_cnt_q == WinLast) state_d = StCapt;
                else win_cnt_d = win_cnt_q + 1'b1;
            end
            StCapt: begin
                if (cs == cs_prev_q) begin
                    sample_d = cs;
                    state_d  = StAcc;
                end else if (try_q == TryLast) begin
                    sample_d = '0;
                    err_d    = 1'b1;
                    state_d  = StAcc;
                end else begin
                    try_d = try_q + 1'b1;
                end
            end
            StAcc: begin
                if (wrap_q) ovf_d = 1'b1;
                acc_d = acc_sum;
                idx_d = idx_q + 1'b1;
                if (idx_q == IdxLast) begin
                    state_d = StDone;
                    data_d  = acc_sum;
                end else begin
                    state_d   = StClr;
                    rst_cnt_d = '0;
                    wrap_d    = 1'b0;
                    try_d     = '0;
                end
            end
            StDone: begin
                if (ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        cnt_rst_d = (state_d == StClr);
    end

    assign cnt_rst_o = cnt_rst_q;
    assign busy_o    = (state_q != StIdle) && (state_q != StDone);
    assign valid_o   = (state_q == StDone);
    assign data_o    = data_q;
    assign ovf_o     = ovf_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_dig_readout.sv
// Directed bench for dig_readout with a behavioural pulse-counter model.
module tb_dig_readout;

    localparam int unsigned RstCyc   = 2;
    localparam int unsigned WinCyc   = 1024;
    localparam int unsigned NAvg     = 4;
    localparam int unsigned SmallWin = 4;

    typedef struct {
        int unsigned lo;
        int unsigned hi;
        bit          ovf;
        bit          err;
    } exp_t;

    logic       clk, rst, start, ready;
    logic [7:0] cnt_in;
    logic       cnt_rst, busy, valid, ovf, err;
    logic [9:0] data;

    logic       start2, ready2;
    logic [7:0] cnt_in2;
    logic       cnt_rst2, busy2, valid2, ovf2, err2;
    logic [7:0] data2;

    int   n_chk, n_fail;
    exp_t sb[$];

    int         period;
    bit         tog_en;
    logic [7:0] cnt_model;
    int         div;

    int pulses, bad_width, run_len;

    dig_readout #(
        .CW(8), .WIN_CYC(WinCyc), .N_AVG(NAvg), .ACC_W(10), .RST_CYC(RstCyc), .MAX_TRY(4)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .cnt_in_i(cnt_in), .cnt_rst_o(cnt_rst),
        .busy_o(busy), .data_o(data), .valid_o(valid), .ready_i(ready), .ovf_o(ovf),
        .err_o(err)
    );

    dig_readout #(
        .CW(8), .WIN_CYC(SmallWin), .N_AVG(1), .ACC_W(8), .RST_CYC(RstCyc), .MAX_TRY(4)
    ) u_dut_small (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .cnt_in_i(cnt_in2), .cnt_rst_o(cnt_rst2),
        .busy_o(busy2), .data_o(data2), .valid_o(valid2), .ready_i(ready2), .ovf_o(ovf2),
        .err_o(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counter: cleared while cnt_rst is high, otherwise counts every 'period' clocks.
    initial begin
        cnt_model = '0;
        div       = 0;
        cnt_in    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (cnt_rst) begin
                cnt_model = '0;
                div       = 0;
            end else begin
                div++;
                if (div >= period) begin
                    div       = 0;
                    cnt_model = cnt_model + 8'd1;
                end
            end
            if (tog_en) cnt_in = (cnt_in == 8'd5) ? 8'd10 : 8'd5;
            else cnt_in = cnt_model;
        end
    end

    // Measures the width of every cnt_rst pulse.
    initial begin
        run_len = 0;
        forever begin
            @(negedge clk);
            if (cnt_rst) begin
                run_len++;
            end else if (run_len > 0) begin
                pulses++;
                if (run_len != RstCyc) bad_width++;
                run_len = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int unsigned obs, input int unsigned lo,
                           input int unsigned hi);
        n_chk++;
        assert (obs >= lo && obs <= hi)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge where valid is seen; cyc counts cycles since start was driven.
    task automatic wait_valid(input int budget, output int cyc, output bit ok);
        cyc = 1;
        ok  = 1'b0;
        while (cyc <= budget) begin
            if (valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL %s: observed result with empty scoreboard expected none", tag);
        end else begin
            e = sb.pop_front();
            chk_rng({tag, "_data"}, int'(data), e.lo, e.hi);
            chk({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
            chk({tag, "_err"}, 32'(err), 32'(e.err));
        end
    endtask

    initial begin
        int         cyc;
        bit         ok;
        logic [9:0] snap;
        int unsigned lat_nom;

        n_chk   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        ready   = 1'b1;
        start2  = 1'b0;
        ready2  = 1'b1;
        cnt_in2 = 8'd7;
        period  = 16;
        tog_en  = 1'b0;
        pulses  = 0;
        bad_width = 0;
        lat_nom = NAvg * (RstCyc + WinCyc + 2) + 1;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_cnt_rst", 32'(cnt_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cnt_rst", 32'(cnt_rst), 32'd0);
        pulses    = 0;
        bad_width = 0;

        // Test 1: slow counter, nominal result.
        sb.push_back('{lo: 252, hi: 260, ovf: 1'b0, err: 1'b0});
        pulse_start();
        chk("t1_busy", 32'(busy), 32'd1);
        wait_valid(5000, cyc, ok);
        chk("t1_valid_seen", 32'(ok), 32'd1);
        chk_rng("t1_latency", cyc, lat_nom, lat_nom + 4);
        check_result("t1");
        @(negedge clk);
        chk("t1_valid_one_cycle", 32'(valid), 32'd0);
        chk("t1_busy_after", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("t1_rst_pulses", 32'(pulses), 32'(NAvg));
        chk("t1_rst_width_bad", 32'(bad_width), 32'd0);

        // Test 2: fast counter wraps every window.
        period = 2;
        sb.push_back('{lo: 1020, hi: 1020, ovf: 1'b1, err: 1'b0});
        pulse_start();
        wait_valid(5000, cyc, ok);
        chk("t2_valid_seen", 32'(ok), 32'd1);
        check_result("t2");

        // Test 3: unstable count through the first capture.
        period = 16;
        sb.push_back('{lo: 189, hi: 195, ovf: 1'b0, err: 1'b1});
        pulse_start();
        repeat (1008) @(negedge clk);
        tog_en = 1'b1;
        repeat (22) @(negedge clk);
        tog_en = 1'b0;
        wait_valid(5000, cyc, ok);
        chk("t3_valid_seen", 32'(ok), 32'd1);
        check_result("t3");

        // Test 4: consumer stalls; start during the hold must be ignored.
        @(negedge clk);
        ready = 1'b0;
        sb.push_back('{lo: 252, hi: 260, ovf: 1'b0, err: 1'b0});
        pulse_start();
        wait_valid(5000, cyc, ok);
        chk("t4_valid_seen", 32'(ok), 32'd1);
        snap = data;
        check_result("t4");
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            start = (i == 25);
            chk("t4_hold_valid", 32'(valid), 32'd1);
            chk("t4_hold_data", 32'(data), 32'(snap));
        end
        start = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        chk("t4_release_valid", 32'(valid), 32'd0);
        chk("t4_release_busy", 32'(busy), 32'd0);
        chk("t4_retain_data", 32'(data), 32'(snap));
        @(negedge clk);
        chk("t4_no_restart", 32'(busy), 32'd0);

        // Test 5: reset in the middle of window 2, then a clean measurement.
        pulse_start();
        repeat (1540) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_cnt_rst", 32'(cnt_rst), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_valid", 32'(valid), 32'd0);
        chk("t5_data", 32'(data), 32'd0);
        chk("t5_ovf", 32'(ovf), 32'd0);
        chk("t5_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sb.push_back('{lo: 252, hi: 260, ovf: 1'b0, err: 1'b0});
        pulse_start();
        wait_valid(5000, cyc, ok);
        chk("t5_valid_seen", 32'(ok), 32'd1);
        chk_rng("t5_latency", cyc, lat_nom, lat_nom + 4);
        check_result("t5");
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);

        // Test 6: single short window on the small instance.
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 1;
        while (!valid2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("t6_valid_seen", 32'(valid2), 32'd1);
        chk("t6_latency", 32'(cyc), 32'(RstCyc + SmallWin + 3));
        chk("t6_data", 32'(data2), 32'd7);
        chk("t6_ovf", 32'(ovf2), 32'd0);
        chk("t6_err", 32'(err2), 32'd0);
        @(negedge clk);
        chk("t6_valid_drop", 32'(valid2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
